// File: rtl/regfile_wr_bank.sv
// Write side of the 32 x DATA_W register file: handshaked one-hot writes, write-done pulse and a sequential clear sweep.
// Optional byte-strobe writes are enabled by defining RF_BYTE_STROBE_EN.
module regfile_wr_bank #(
  parameter int DATA_W  = 32,
  parameter int ADDR_W  = 5,
  parameter int NREGS   = 32,
  parameter int ZERO_R0 = 1
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_wr_valid,
  output logic              o_wr_ready,
  input  logic [ADDR_W-1:0] i_wr_addr,
  input  logic [DATA_W-1:0] i_wr_data,
`ifdef RF_BYTE_STROBE_EN
  input  logic [DATA_W/8-1:0] i_wr_strb,
`endif
  output logic              o_wr_done,
  input  logic              i_clr_req,
  output logic              o_clr_busy,
  output logic [DATA_W-1:0] o_regs_out [0:NREGS-1]
);

  localparam int NBYTES = DATA_W / 8;
  localparam int CNT_W  = ADDR_W + 1;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(NREGS - 1);

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_CLEAR = 1'b1
  } state_t;

  state_t              r_state;
  logic [CNT_W-1:0]    r_clr_cnt;
  logic                r_clr_busy;
  logic                r_wr_done;
  logic [DATA_W-1:0]   r_regs [0:NREGS-1];

  logic                w_accept;
  logic [NREGS-1:0]    w_wr_onehot;
  logic [NREGS-1:0]    w_clr_onehot;
  logic [DATA_W-1:0]   w_strb_mask;

  function automatic logic [DATA_W-1:0] strb_to_mask(input logic [NBYTES-1:0] strb);
    logic [DATA_W-1:0] mask;
    mask = {DATA_W{1'b0}};
    for (int b = 0; b < NBYTES; b++) begin
      mask[b*8 +: 8] = {8{strb[b]}};
    end
    return mask;
  endfunction

  // Handshake: a pending clear request takes precedence over a write in IDLE.
  always_comb begin
    o_wr_ready = 1'b0;
    if (r_state == ST_IDLE) begin
      o_wr_ready = ~i_clr_req;
    end else begin
      o_wr_ready = 1'b0;
    end
    w_accept = i_wr_valid & o_wr_ready;
  end

  // Address and sweep-counter decode to one-hot register enables.
  always_comb begin
    w_wr_onehot  = {NREGS{1'b0}};
    w_clr_onehot = {NREGS{1'b0}};
    for (int i = 0; i < NREGS; i++) begin
      w_wr_onehot[i]  = w_accept && (i_wr_addr == ADDR_W'(i));
      w_clr_onehot[i] = (r_state == ST_CLEAR) && (r_clr_cnt == CNT_W'(i));
    end
  end

  // Byte-lane write mask.
  always_comb begin
`ifdef RF_BYTE_STROBE_EN
    w_strb_mask = strb_to_mask(i_wr_strb);
`else
    w_strb_mask = strb_to_mask({NBYTES{1'b1}});
`endif
  end

  // Control FSM: IDLE accepts writes, CLEAR sweeps one register per cycle.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state    <= ST_IDLE;
      r_clr_cnt  <= {CNT_W{1'b0}};
      r_clr_busy <= 1'b0;
      r_wr_done  <= 1'b0;
    end else begin
      r_wr_done <= w_accept;
      case (r_state)
        ST_IDLE: begin
          if (i_clr_req) begin
            r_state    <= ST_CLEAR;
            r_clr_cnt  <= {CNT_W{1'b0}};
            r_clr_busy <= 1'b1;
          end else begin
            r_state    <= ST_IDLE;
            r_clr_cnt  <= r_clr_cnt;
            r_clr_busy <= 1'b0;
          end
        end
        ST_CLEAR: begin
          if (r_clr_cnt == LAST_CNT) begin
            r_state    <= ST_IDLE;
            r_clr_cnt  <= {CNT_W{1'b0}};
            r_clr_busy <= 1'b0;
          end else begin
            r_state    <= ST_CLEAR;
            r_clr_cnt  <= r_clr_cnt + CNT_W'(1);
            r_clr_busy <= 1'b1;
          end
        end
        default: begin
          r_state    <= ST_IDLE;
          r_clr_cnt  <= {CNT_W{1'b0}};
          r_clr_busy <= 1'b0;
        end
      endcase
    end
  end

  // Register array; the sweep and a write never coincide because wr_ready is low in CLEAR.
  always_ff @(posedge i_clk) begin
    for (int i = 0; i < NREGS; i++) begin
      if (i_rst) begin
        r_regs[i] <= {DATA_W{1'b0}};
      end else if ((ZERO_R0 != 0) && (i == 0)) begin
        r_regs[i] <= {DATA_W{1'b0}};
      end else if (w_clr_onehot[i]) begin
        r_regs[i] <= {DATA_W{1'b0}};
      end else if (w_wr_onehot[i]) begin
        r_regs[i] <= (r_regs[i] & ~w_strb_mask) | (i_wr_data & w_strb_mask);
      end else begin
        r_regs[i] <= r_regs[i];
      end
    end
  end

  // Expose the array; register 0 is tied off when hardwired to zero.
  always_comb begin
    for (int i = 0; i < NREGS; i++) begin
      if ((ZERO_R0 != 0) && (i == 0)) begin
        o_regs_out[i] = {DATA_W{1'b0}};
      end else begin
        o_regs_out[i] = r_regs[i];
      end
    end
  end

  assign o_wr_done  = r_wr_done;
  assign o_clr_busy = r_clr_busy;

endmodule
